fmult_accum_sched: RTL

FMULT_ACCUM_SCHED -- requirements
Module: fmult_accum_sched

---
 rtl/fmult_accum_sched_pkg.sv | 15 +
 rtl/fmult_accum_rr_arb.sv | 27 ++
 rtl/fmult_accum_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fmult_accum_sched_pkg.sv
// Shared types and widths for the FMULT_ACCUM channel scheduler.
package fmult_accum_sched_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int COEF_W     = 16;
  localparam int HIST_W     = 11;
  localparam int EST_W      = 15;
  localparam int NOPS       = 8;
  localparam int COEF_BUS_W = COEF_W * NOPS;
  localparam int HIST_BUS_W = HIST_W * NOPS;
endpackage

// File: rtl/fmult_accum_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins, one-hot grant.
module fmult_accum_rr_arb #(
  parameter int NCH = 4,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] grant
);
  logic [PW:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NCH))
        idx = idx - (PW+1)'(NCH);
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fmult_accum_sched.sv
// Channel scheduler feeding one shared FMULT_ACCUM unit.
// Optional watchdog: define FMULT_ACCUM_SCHED_TIMEOUT_EN.
module fmult_accum_sched
  import fmult_accum_sched_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int TO_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scan_in0,
  input  logic                      scan_in1,
  input  logic                      scan_in2,
  input  logic                      scan_in3,
  input  logic                      scan_in4,
  input  logic                      scan_enable,
  input  logic                      test_mode,
  output logic                      scan_out0,
  output logic                      scan_out1,
  output logic                      scan_out2,
  output logic                      scan_out3,
  output logic                      scan_out4,
  input  logic [NCH-1:0]            ch_req,
  input  logic [NCH*COEF_BUS_W-1:0] ch_coef,
  input  logic [NCH*HIST_BUS_W-1:0] ch_hist,
  output logic [NCH-1:0]            ch_ack,
  output logic [EST_W-1:0]          rd_se,
  output logic [EST_W-1:0]          rd_sez,
  output logic                      rd_err,
  output logic [COEF_BUS_W-1:0]     fa_coef,
  output logic [HIST_BUS_W-1:0]     fa_hist,
  output logic                      fa_start,
  input  logic [EST_W-1:0]          fa_se,
  input  logic [EST_W-1:0]          fa_sez,
  input  logic                      fa_done
);
  localparam int PW = $clog2(NCH);

  if (NCH < 2 || NCH > 8 || TO_CYCLES < 1) begin : g_cfg_err
    $error("fmult_accum_sched: parameter out of range");
  end

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         gnt_q, gnt_d;
  logic [PW-1:0]         gidx;
  logic [NCH-1:0]        grant;
  logic                  start_q, start_d;
  logic [EST_W-1:0]      se_q, se_d;
  logic [EST_W-1:0]      sez_q, sez_d;
  logic [COEF_BUS_W-1:0] coef_q, coef_d;
  logic [HIST_BUS_W-1:0] hist_q, hist_d;
  logic [4:0]            scan_q;
  logic                  to_hit;

  logic [COEF_BUS_W-1:0] coef_arr [NCH];
  logic [HIST_BUS_W-1:0] hist_arr [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_slice
    assign coef_arr[g] = ch_coef[g*COEF_BUS_W +: COEF_BUS_W];
    assign hist_arr[g] = ch_hist[g*HIST_BUS_W +: HIST_BUS_W];
  end

  fmult_accum_rr_arb #(
    .NCH (NCH),
    .PW  (PW)
  ) u_arb (
    .req   (ch_req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) gidx = PW'(i);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    start_d = start_q;
    se_d    = se_q;
    sez_d   = sez_q;
    coef_d  = coef_q;
    hist_d  = hist_q;
    unique case (state_q)
      S_IDLE: begin
        if (|ch_req) begin
          gnt_d   = gidx;
          coef_d  = coef_arr[gidx];
          hist_d  = hist_arr[gidx];
          start_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (fa_done) begin
          se_d    = fa_se;
          sez_d   = fa_sez;
          start_d = 1'b0;
          state_d = S_RESP;
        end else if (to_hit) begin
          se_d    = '0;
          sez_d   = '0;
          start_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = (gnt_q == PW'(NCH-1)) ? '0 : gnt_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      se_q    <= '0;
      sez_q   <= '0;
      coef_q  <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      se_q    <= se_d;
      sez_q   <= sez_d;
      coef_q  <= coef_d;
      hist_q  <= hist_d;
    end
  end

`ifdef FMULT_ACCUM_SCHED_TIMEOUT_EN
  localparam int TW =
    ($clog2(TO_CYCLES+1) > 8) ? $clog2(TO_CYCLES+1) : 8;
  logic [TW-1:0] cnt_q;
  logic          err_q;

  assign to_hit = (cnt_q == TW'(TO_CYCLES-1));
  assign rd_err = err_q;

  // Counter restarts on every entry to RUN; error lives only through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_RUN) ? cnt_q + TW'(1) : '0;
      if (state_q == S_RUN)
        err_q <= !fa_done && to_hit;
      else if (state_q == S_RESP)
        err_q <= 1'b0;
    end
  end
`else
  assign to_hit = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Scan capture is gated off entirely outside test mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      scan_q <= '0;
    else if (test_mode && scan_enable)
      scan_q <= {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};
    else
      scan_q <= '0;
  end

  assign {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0} = scan_q;

  assign ch_ack   = (state_q == S_RESP) ? NCH'(1) << gnt_q : '0;
  assign rd_se    = se_q;
  assign rd_sez   = sez_q;
  assign fa_start = start_q;
  assign fa_coef  = coef_q;
  assign fa_hist  = hist_q;
endmodule
